// File: rtl/sdrc_app_responder.sv
// sdrc_app_responder: stand-in for the SDRAM controller core on the app_* request
// interface. It acknowledges requests, consumes write bursts into an internal word
// array and returns read bursts from it, with fixed init, ack and read latencies.
// Ports:
//   wb_clk_i, wb_rst_i          clock and synchronous active-high reset
//   app_req, app_req_addr/len/wr_n, app_req_ack
//                               request handshake with a one-cycle ack pulse
//   app_busy_n                  high while idle and able to accept a request
//   app_wr_en_n, app_wr_data    write beat byte enables (active low) and data
//   app_wr_next_req, app_last_wr
//                               write beat consumed this cycle / final write beat
//   app_rd_valid, app_rd_data, app_last_rd
//                               read beat valid, data and final-beat flag
//   sdr_init_done               high once the post-reset init period has elapsed
module sdrc_app_responder #(
  parameter int unsigned APP_AW   = 26,
  parameter int unsigned APP_DW   = 32,
  parameter int unsigned APP_BW   = 4,
  parameter int unsigned bl       = 9,
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned INIT_CYC = 16,
  parameter int unsigned ACK_DLY  = 2,
  parameter int unsigned RD_LAT   = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              app_req,
  input  logic [APP_AW-1:0] app_req_addr,
  input  logic [bl-1:0]     app_req_len,
  input  logic              app_req_wr_n,
  output logic              app_req_ack,
  output logic              app_busy_n,
  input  logic [APP_BW-1:0] app_wr_en_n,
  input  logic [APP_DW-1:0] app_wr_data,
  output logic              app_wr_next_req,
  output logic              app_last_wr,
  output logic              app_rd_valid,
  output logic [APP_DW-1:0] app_rd_data,
  output logic              app_last_rd,
  output logic              sdr_init_done
);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_ACK_WAIT, ST_WRITE, ST_RD_WAIT, ST_READ
  } state_e;

  localparam int unsigned DLY_MAX   = (INIT_CYC > ACK_DLY) ?
                                      ((INIT_CYC > RD_LAT) ? INIT_CYC : RD_LAT) :
                                      ((ACK_DLY > RD_LAT) ? ACK_DLY : RD_LAT);
  localparam int unsigned DLY_W     = $clog2(DLY_MAX + 1);
  localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

  state_e              state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [bl-1:0]       beat_q, beat_d;
  logic [bl-1:0]       len_q, len_d, len_eff;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic                wr_n_q, wr_n_d;
  logic                beat_go;
  logic                ack_d, busy_n_d, next_req_d, last_wr_d;
  logic                rd_valid_d, last_rd_d, init_done_d;
  logic [APP_DW-1:0]   rd_data_d;
  logic [APP_DW-1:0]   mem [MEM_DEPTH];
  logic                addr_unused;

  // Upper request address bits are intentionally dropped.
  assign addr_unused = ^app_req_addr[APP_AW-1:MEM_AW];

  // A zero-length request still moves one word.
  assign len_eff = (len_q == '0) ? bl'(1) : len_q;
  assign beat_go = (beat_q != len_eff);

  // State and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q         <= ST_INIT;
      dly_q           <= '0;
      beat_q          <= '0;
      len_q           <= '0;
      ptr_q           <= '0;
      wr_n_q          <= 1'b0;
      app_req_ack     <= 1'b0;
      app_busy_n      <= 1'b0;
      app_wr_next_req <= 1'b0;
      app_last_wr     <= 1'b0;
      app_rd_valid    <= 1'b0;
      app_last_rd     <= 1'b0;
      sdr_init_done   <= 1'b0;
      app_rd_data     <= '0;
    end else begin
      state_q         <= state_d;
      dly_q           <= dly_d;
      beat_q          <= beat_d;
      len_q           <= len_d;
      ptr_q           <= ptr_d;
      wr_n_q          <= wr_n_d;
      app_req_ack     <= ack_d;
      app_busy_n      <= busy_n_d;
      app_wr_next_req <= next_req_d;
      app_last_wr     <= last_wr_d;
      app_rd_valid    <= rd_valid_d;
      app_last_rd     <= last_rd_d;
      sdr_init_done   <= init_done_d;
      app_rd_data     <= rd_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:     if (dly_q == DLY_W'(INIT_CYC - 1)) state_d = ST_IDLE;
      ST_IDLE:     if (app_req) state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: if (dly_q == DLY_W'(ACK_DLY - 1)) state_d = wr_n_q ? ST_RD_WAIT : ST_WRITE;
      // The ack cycle counts as the first read-latency cycle and READ issues a beat
      // on its first edge, hence RD_LAT-2.
      ST_RD_WAIT:  if (dly_q == DLY_W'(RD_LAT - 2)) state_d = ST_READ;
      ST_WRITE,
      ST_READ:     if (!beat_go) state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    dly_d       = (state_d == state_q) ? dly_q + DLY_W'(1) : '0;
    beat_d      = beat_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    wr_n_d      = wr_n_q;
    ack_d       = 1'b0;
    busy_n_d    = 1'b0;
    next_req_d  = 1'b0;
    last_wr_d   = 1'b0;
    rd_valid_d  = 1'b0;
    last_rd_d   = 1'b0;
    init_done_d = sdr_init_done;
    rd_data_d   = app_rd_data;
    case (state_q)
      ST_INIT: begin
        if (state_d == ST_IDLE) begin
          init_done_d = 1'b1;
          busy_n_d    = 1'b1;
        end
      end
      ST_IDLE: begin
        busy_n_d = ~app_req;
        if (app_req) begin
          ptr_d  = app_req_addr[MEM_AW-1:0];
          len_d  = app_req_len;
          wr_n_d = app_req_wr_n;
        end
      end
      ST_ACK_WAIT: begin
        if (state_d != state_q) begin
          ack_d  = 1'b1;
          beat_d = '0;
        end
      end
      ST_WRITE: begin
        // A beat offered last cycle is committed on this edge.
        if (app_wr_next_req) ptr_d = ptr_q + MEM_AW'(1);
        if (beat_go) begin
          next_req_d = 1'b1;
          last_wr_d  = (beat_q == len_eff - bl'(1));
          beat_d     = beat_q + bl'(1);
        end else begin
          busy_n_d = 1'b1;
        end
      end
      ST_READ: begin
        if (beat_go) begin
          rd_valid_d = 1'b1;
          last_rd_d  = (beat_q == len_eff - bl'(1));
          rd_data_d  = mem[ptr_q];
          ptr_d      = ptr_q + MEM_AW'(1);
          beat_d     = beat_q + bl'(1);
        end else begin
          busy_n_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Word array with per-byte write enables; never reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && state_q == ST_WRITE && app_wr_next_req) begin
      for (int unsigned i = 0; i < APP_BW; i++) begin
        if (!app_wr_en_n[i]) mem[ptr_q][8*i +: 8] <= app_wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sdrc_app_responder.sv
// Randomized self-checking bench for sdrc_app_responder against a word-array model.
module tb_sdrc_app_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        app_req;
  logic [25:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack;
  logic        app_busy_n;
  logic [3:0]  app_wr_en_n;
  logic [31:0] app_wr_data;
  logic        app_wr_next_req;
  logic        app_last_wr;
  logic        app_rd_valid;
  logic [31:0] app_rd_data;
  logic        app_last_rd;
  logic        sdr_init_done;

  always #5 clk = ~clk;

  sdrc_app_responder dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .app_req         (app_req),
    .app_req_addr    (app_req_addr),
    .app_req_len     (app_req_len),
    .app_req_wr_n    (app_req_wr_n),
    .app_req_ack     (app_req_ack),
    .app_busy_n      (app_busy_n),
    .app_wr_en_n     (app_wr_en_n),
    .app_wr_data     (app_wr_data),
    .app_wr_next_req (app_wr_next_req),
    .app_last_wr     (app_last_wr),
    .app_rd_valid    (app_rd_valid),
    .app_rd_data     (app_rd_data),
    .app_last_rd     (app_last_rd),
    .sdr_init_done   (sdr_init_done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wdat [512];
  logic [3:0]  wen  [512];
  logic [31:0] rdat [512];

  int obs_beats, obs_acks, obs_ack_lat, obs_first_lat, obs_last_cnt, obs_last_beat;
  int obs_viol, obs_timeout, obs_busy_acc;

  function automatic int eff_len(input logic [8:0] len);
    return (len == 9'd0) ? 1 : int'(len);
  endfunction

  // Commit a write burst (wdat/wen) into the model, wrapping in the array.
  function automatic void model_write(input logic [25:0] addr, input logic [8:0] len);
    for (int i = 0; i < eff_len(len); i++) begin
      int a;
      a = (int'(addr[7:0]) + i) % DEPTH;
      for (int b = 0; b < 4; b++)
        if (!wen[i][b]) model_mem[a][8*b +: 8] = wdat[i][8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_rd(input logic [25:0] addr, input int i);
    return model_mem[(int'(addr[7:0]) + i) % DEPTH];
  endfunction

  // Run one burst from an idle bus, recording latencies, beats and protocol violations.
  task automatic run_burst(input logic wr_n, input logic [25:0] addr, input logic [8:0] len,
                           input bit hold_req);
    int  k;
    bit  started;
    bit  finished;
    logic beat;
    logic other;
    obs_beats = 0; obs_acks = 0; obs_ack_lat = -1; obs_first_lat = -1;
    obs_last_cnt = 0; obs_last_beat = -1; obs_viol = 0; obs_timeout = 0; obs_busy_acc = -1;
    for (int c = 0; c < 200 && app_busy_n !== 1'b1; c++) @(negedge clk);
    if (app_busy_n !== 1'b1) begin
      obs_timeout = 1;
      return;
    end
    app_req = 1'b1; app_req_addr = addr; app_req_len = len; app_req_wr_n = wr_n;
    k = 0; started = 0; finished = 0;
    while (!finished && k < 1200) begin
      @(negedge clk);
      k++;
      if (k == 1) obs_busy_acc = int'(app_busy_n);
      if (app_req_ack === 1'b1) begin
        obs_acks++;
        if (obs_ack_lat < 0) obs_ack_lat = k - 1;
        app_req = 1'b0;
      end else if (k >= 1 && app_req) begin
        if (hold_req) begin
          app_req_addr = 26'($urandom); app_req_len = 9'($urandom); app_req_wr_n = 1'($urandom);
        end else begin
          app_req = 1'b0;
        end
      end
      if (app_wr_next_req === 1'b1 && app_rd_valid === 1'b1) obs_viol++;
      if (app_last_wr === 1'b1 && app_wr_next_req !== 1'b1) obs_viol++;
      if (app_last_rd === 1'b1 && app_rd_valid !== 1'b1) obs_viol++;
      beat  = wr_n ? app_rd_valid : app_wr_next_req;
      other = wr_n ? app_wr_next_req : app_rd_valid;
      if (other === 1'b1) obs_viol++;
      if (beat === 1'b1) begin
        if (!started) begin
          started = 1;
          obs_first_lat = (k - 1) - obs_ack_lat;
        end
        if (obs_beats < 512) begin
          if (wr_n) rdat[obs_beats] = app_rd_data;
          else begin
            app_wr_data = wdat[obs_beats];
            app_wr_en_n = wen[obs_beats];
          end
        end
        if ((wr_n ? app_last_rd : app_last_wr) === 1'b1) begin
          obs_last_cnt++;
          obs_last_beat = obs_beats;
        end
        obs_beats++;
      end else begin
        app_wr_data = $urandom;
        app_wr_en_n = 4'h0;
        if (started) finished = 1;
      end
    end
    app_req = 1'b0;
    if (!finished) obs_timeout = 1;
  endtask

  task automatic test_reset();
    int done_at;
    int ack_seen;
    int busy_early;
    int bad;
    rst = 1'b1; app_req = 1'b0; app_req_addr = '0; app_req_len = '0; app_req_wr_n = 1'b1;
    app_wr_en_n = 4'hF; app_wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({app_req_ack, app_busy_n, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd,
         sdr_init_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000", {app_req_ack, app_busy_n,
               app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd, sdr_init_done});
    end
    checks++;
    if (app_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 0", app_rd_data);
    end
    // A request held during init must be ignored.
    app_req = 1'b1; app_req_wr_n = 1'b0; app_req_addr = 26'($urandom); app_req_len = 9'd4;
    rst = 1'b0;
    done_at = -1; ack_seen = 0; busy_early = 0;
    for (int p = 1; p <= 40 && done_at < 0; p++) begin
      @(negedge clk);
      if (app_req_ack === 1'b1) ack_seen++;
      if (sdr_init_done === 1'b1) done_at = p;
      else if (app_busy_n !== 1'b0) busy_early++;
      if (p == 15) app_req = 1'b0;
    end
    checks++;
    if (done_at != 16) begin
      errors++;
      $display("FAIL init_done_cycle: got %0d expected 16", done_at);
    end
    checks++;
    if (app_busy_n !== 1'b1) begin
      errors++;
      $display("FAIL busy_n_at_init_done: got %b expected 1", app_busy_n);
    end
    checks++;
    if (ack_seen != 0 || busy_early != 0) begin
      errors++;
      $display("FAIL req_ignored_in_init: got acks %0d busy_early %0d expected 0 0",
               ack_seen, busy_early);
    end
    bad = 0;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      if (sdr_init_done !== 1'b1 || app_busy_n !== 1'b1 || app_req_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_init: got %0d bad cycles expected 0", bad);
    end
  endtask

  // Fill the whole array with a max-length wrapping write, then a max-length read.
  task automatic test_max_len();
    logic [25:0] ra;
    int bad;
    for (int i = 0; i < 511; i++) begin
      wdat[i] = $urandom; wen[i] = 4'h0;
    end
    run_burst(1'b0, 26'h0, 9'd511, 1'b0);
    model_write(26'h0, 9'd511);
    checks++;
    if (obs_beats != 511 || obs_last_beat != 510 || obs_last_cnt != 1 || obs_timeout != 0) begin
      errors++;
      $display("FAIL max_write: got beats %0d last_at %0d lasts %0d to %0d expected 511 510 1 0",
               obs_beats, obs_last_beat, obs_last_cnt, obs_timeout);
    end
    ra = 26'($urandom);
    run_burst(1'b1, ra, 9'd511, 1'b0);
    checks++;
    if (obs_beats != 511 || obs_last_beat != 510 || obs_viol != 0) begin
      errors++;
      $display("FAIL max_read: got beats %0d last_at %0d viol %0d expected 511 510 0",
               obs_beats, obs_last_beat, obs_viol);
    end
    bad = 0;
    for (int i = 0; i < 511; i++) if (rdat[i] !== model_rd(ra, i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL max_read_data: got %0d wrong words expected 0", bad);
    end
  endtask

  task automatic test_write_basic();
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'hA0 + 32'(i); wen[i] = 4'h0;
    end
    run_burst(1'b0, 26'h10, 9'd4, 1'b0);
    model_write(26'h10, 9'd4);
    checks++;
    if (obs_ack_lat != 2 || obs_acks != 1) begin
      errors++;
      $display("FAIL wr_ack: got lat %0d acks %0d expected 2 1", obs_ack_lat, obs_acks);
    end
    checks++;
    if (obs_busy_acc != 0) begin
      errors++;
      $display("FAIL wr_busy_after_accept: got %0d expected 0", obs_busy_acc);
    end
    checks++;
    if (obs_first_lat != 1 || obs_beats != 4) begin
      errors++;
      $display("FAIL wr_beats: got first_lat %0d beats %0d expected 1 4", obs_first_lat, obs_beats);
    end
    checks++;
    if (obs_last_beat != 3 || obs_last_cnt != 1 || obs_viol != 0 || obs_timeout != 0) begin
      errors++;
      $display("FAIL wr_last: got last_at %0d lasts %0d viol %0d to %0d expected 3 1 0 0",
               obs_last_beat, obs_last_cnt, obs_viol, obs_timeout);
    end
  endtask

  task automatic test_read_basic();
    run_burst(1'b1, 26'h10, 9'd4, 1'b0);
    checks++;
    if (obs_ack_lat != 2 || obs_first_lat != 3 || obs_beats != 4) begin
      errors++;
      $display("FAIL rd_timing: got ack %0d first %0d beats %0d expected 2 3 4",
               obs_ack_lat, obs_first_lat, obs_beats);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL rd_data[%0d]: got %h expected %h", i, rdat[i], 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (obs_last_beat != 3 || obs_last_cnt != 1 || obs_viol != 0) begin
      errors++;
      $display("FAIL rd_last: got last_at %0d lasts %0d viol %0d expected 3 1 0",
               obs_last_beat, obs_last_cnt, obs_viol);
    end
  endtask

  task automatic test_byte_en();
    wdat[0] = 32'hFFFF_FFFF; wen[0] = 4'h0;
    run_burst(1'b0, 26'h20, 9'd1, 1'b0);
    model_write(26'h20, 9'd1);
    wdat[0] = 32'h1234_5678; wen[0] = 4'b1010;
    run_burst(1'b0, 26'h20, 9'd1, 1'b1);
    model_write(26'h20, 9'd1);
    run_burst(1'b1, 26'h20, 9'd1, 1'b0);
    checks++;
    if (rdat[0] !== 32'hFF34_FF78 || obs_beats != 1) begin
      errors++;
      $display("FAIL byte_en: got %h beats %0d expected ff34ff78 1", rdat[0], obs_beats);
    end
  endtask

  task automatic test_wrap_len0();
    logic [25:0] a;
    a = {18'($urandom), 8'hFF};
    for (int i = 0; i < 3; i++) begin
      wdat[i] = $urandom; wen[i] = 4'h0;
    end
    run_burst(1'b0, a, 9'd3, 1'b0);
    model_write(a, 9'd3);
    run_burst(1'b1, 26'h0, 9'd2, 1'b0);
    checks++;
    if (rdat[0] !== wdat[1] || rdat[1] !== wdat[2]) begin
      errors++;
      $display("FAIL wrap_low_words: got %h %h expected %h %h", rdat[0], rdat[1], wdat[1], wdat[2]);
    end
    run_burst(1'b1, {18'($urandom), 8'hFF}, 9'd3, 1'b0);
    checks++;
    if (rdat[0] !== wdat[0] || rdat[1] !== wdat[1] || rdat[2] !== wdat[2]) begin
      errors++;
      $display("FAIL wrap_readback: got %h %h %h expected %h %h %h",
               rdat[0], rdat[1], rdat[2], wdat[0], wdat[1], wdat[2]);
    end
    a = 26'($urandom);
    run_burst(1'b1, a, 9'd0, 1'b0);
    checks++;
    if (obs_beats != 1 || obs_last_cnt != 1 || obs_last_beat != 0 || rdat[0] !== model_rd(a, 0)) begin
      errors++;
      $display("FAIL len0_read: got beats %0d lasts %0d data %h expected 1 1 %h",
               obs_beats, obs_last_cnt, rdat[0], model_rd(a, 0));
    end
    wdat[0] = $urandom; wen[0] = 4'h0;
    run_burst(1'b0, a, 9'd0, 1'b0);
    model_write(a, 9'd0);
    checks++;
    if (obs_beats != 1 || obs_last_beat != 0) begin
      errors++;
      $display("FAIL len0_write: got beats %0d last_at %0d expected 1 0", obs_beats, obs_last_beat);
    end
  endtask

  task automatic test_random();
    logic        wr_n;
    logic [25:0] a;
    logic [8:0]  len;
    bit          hold;
    int          n;
    int          bad;
    for (int t = 0; t < 40; t++) begin
      wr_n = 1'($urandom_range(0, 1));
      a    = 26'($urandom);
      len  = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
      hold = 1'($urandom_range(0, 1));
      n    = eff_len(len);
      for (int i = 0; i < n; i++) begin
        wdat[i] = $urandom; wen[i] = 4'($urandom);
      end
      run_burst(wr_n, a, len, hold);
      if (!wr_n) model_write(a, len);
      checks++;
      if (obs_beats != n || obs_last_beat != n - 1 || obs_last_cnt != 1 || obs_acks != 1 ||
          obs_ack_lat != 2 || obs_first_lat != (wr_n ? 3 : 1) || obs_viol != 0 || obs_timeout != 0) begin
        errors++;
        $display("FAIL rand[%0d]: got beats %0d last_at %0d lasts %0d acks %0d ack %0d first %0d viol %0d to %0d expected %0d %0d 1 1 2 %0d 0 0",
                 t, obs_beats, obs_last_beat, obs_last_cnt, obs_acks, obs_ack_lat, obs_first_lat,
                 obs_viol, obs_timeout, n, n - 1, wr_n ? 3 : 1);
      end
      if (wr_n) begin
        bad = 0;
        for (int i = 0; i < n && i < obs_beats; i++) if (rdat[i] !== model_rd(a, i)) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %0d wrong words expected 0", t, bad);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [25:0] a;
    int beats;
    int done_at;
    int bad;
    a = 26'($urandom);
    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom; wen[i] = 4'h0;
    end
    run_burst(1'b0, a, 9'd8, 1'b0);
    model_write(a, 9'd8);
    for (int c = 0; c < 50 && app_busy_n !== 1'b1; c++) @(negedge clk);
    app_req = 1'b1; app_req_addr = a; app_req_len = 9'd8; app_req_wr_n = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && beats < 2; c++) begin
      @(negedge clk);
      app_req = 1'b0;
      if (app_rd_valid === 1'b1) beats++;
    end
    checks++;
    if (beats != 2) begin
      errors++;
      $display("FAIL mid_read_start: got %0d beats expected 2", beats);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (app_rd_valid !== 1'b0 || sdr_init_done !== 1'b0 || app_busy_n !== 1'b0 ||
        app_last_rd !== 1'b0 || app_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_read_reset: got valid %b done %b busy_n %b last %b data %h expected 0 0 0 0 0",
               app_rd_valid, sdr_init_done, app_busy_n, app_last_rd, app_rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    done_at = -1; bad = 0;
    for (int p = 1; p <= 40 && done_at < 0; p++) begin
      @(negedge clk);
      if (app_rd_valid !== 1'b0) bad++;
      if (sdr_init_done === 1'b1) done_at = p;
    end
    checks++;
    if (done_at != 16 || bad != 0) begin
      errors++;
      $display("FAIL reinit: got done_at %0d stray beats %0d expected 16 0", done_at, bad);
    end
    run_burst(1'b1, a, 9'd8, 1'b0);
    bad = 0;
    for (int i = 0; i < 8; i++) if (rdat[i] !== model_rd(a, i)) bad++;
    checks++;
    if (bad != 0 || obs_beats != 8) begin
      errors++;
      $display("FAIL data_after_reset: got %0d wrong words beats %0d expected 0 8", bad, obs_beats);
    end
    run_burst(1'b1, 26'h20, 9'd1, 1'b0);
    checks++;
    if (rdat[0] !== model_rd(26'h20, 0)) begin
      errors++;
      $display("FAIL old_data_after_reset: got %h expected %h", rdat[0], model_rd(26'h20, 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_max_len();
    test_write_basic();
    test_read_basic();
    test_byte_en();
    test_wrap_len0();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrc_app_responder.md
Name: sdrc_app_responder

Overview:
- Behavioural/synthesizable responder for the SDRAM-controller application ("app_*") request interface. It stands in for the SDRAM core.
- It accepts app requests, acknowledges them, pulls burst write data and returns burst read data from an internal word array.
- It lets the Wishbone-to-app bridge be exercised and whitebox-checked without an SDRAM model.
- It sits on the `TOP_PATH` app_* nets in place of the controller core.

Parameters:
- APP_AW, 26, application address width
- APP_DW, 32, application data width
- APP_BW, 4, application byte-enable width (APP_DW/8)
- bl, 9, burst length field width
- MEM_AW, 8, internal array word-address width (depth 2**MEM_AW)
- INIT_CYC, 16, cycles after reset before sdr_init_done rises
- ACK_DLY, 2, cycles from request acceptance to app_req_ack
- RD_LAT, 3, cycles from ack to first app_rd_valid

Ports:
- wb_clk_i, in, 1: clock; all logic rising-edge
- wb_rst_i, in, 1: synchronous active-high reset
- app_req, in, 1: request valid
- app_req_addr, in, APP_AW: start word address
- app_req_len, in, bl: burst length in words
- app_req_wr_n, in, 1: 0 = write, 1 = read
- app_req_ack, out, 1: one-cycle request-accepted pulse
- app_busy_n, out, 1: 1 = idle, able to accept a request
- app_wr_en_n, in, APP_BW: active-low byte write enables
- app_wr_data, in, APP_DW: write data
- app_wr_next_req, out, 1: write beat consumed this cycle
- app_last_wr, out, 1: final write beat
- app_rd_valid, out, 1: read data valid
- app_rd_data, out, APP_DW: read data
- app_last_rd, out, 1: final read beat
- sdr_init_done, out, 1: initialization complete

Behaviour:
- Reset, next edge after wb_rst_i=1: state=INIT. All outputs 0, including app_busy_n=0 and app_rd_data=0. Counters cleared.
- Reset mid-burst aborts the burst with no further beats. Array contents are never reset.
- INIT: count INIT_CYC cycles, then sdr_init_done=1 (sticky until reset) and go to IDLE. app_req is ignored while in INIT.
- IDLE:
  - app_busy_n=1.
  - On app_req=1, latch addr[MEM_AW-1:0], len and wr_n; app_busy_n=0 from the next cycle; go to ACK_WAIT.
  - A latched len=0 is treated as 1.
  - Upper address bits are ignored.
- ACK_WAIT:
  - Wait ACK_DLY cycles, then assert app_req_ack for exactly 1 cycle.
  - Next state is WRITE if wr_n=0, else RD_WAIT.
  - Changes on app_req after latch are ignored; app_req held high after ack is not re-accepted until back in IDLE.
- WRITE:
  - app_wr_next_req=1 for len consecutive cycles, starting the cycle after ack.
  - In each such cycle, app_wr_data is sampled. Byte i of array[ptr] is written iff app_wr_en_n[i]=0.
  - ptr increments mod 2**MEM_AW (wraps 255->0 at default).
  - app_last_wr=1 only on the final next_req cycle. Then go to IDLE.
- RD_WAIT: wait RD_LAT cycles after the ack cycle, then go to READ.
- READ:
  - app_rd_valid=1 for len consecutive cycles. app_rd_data=array[ptr], registered; ptr wraps as in WRITE.
  - app_last_rd=1 only on the final beat. Then go to IDLE.
  - app_rd_data holds its last value when app_rd_valid=0.
- Exclusivity:
  - At most one burst is outstanding.
  - app_wr_next_req and app_rd_valid are never both 1.
  - app_last_wr implies app_wr_next_req; app_last_rd implies app_rd_valid.
- Max burst: len=511, giving 511 beats. The beat counter is bl bits wide.

Test Plan:
- Reset release: sdr_init_done rises exactly 16 cycles after wb_rst_i falls; app_busy_n=1 from the same cycle.
- Write burst, addr=0x10, len=4, data 0xA0..0xA3, wr_en_n=0 -> ack 2 cycles after acceptance; 4 next_req beats; last_wr on beat 4.
- Read burst, addr=0x10, len=4 -> rd_valid starts 3 cycles after ack; returns 0xA0..0xA3; last_rd on 0xA3.
- Byte enables: write 0xFFFFFFFF to 0x20, then 0x12345678 with wr_en_n=4'b1010 -> read of 0x20 returns 0xFF34FF78.
- Wrap and len=0:
  - Write len=3 at 0xFF -> words land at 0xFF, 0x00, 0x01; readback matches.
  - A len=0 read gives exactly 1 beat with last_rd=1.
- Reset mid-read: assert wb_rst_i on beat 2 of a len=8 read -> rd_valid=0 next edge; sdr_init_done=0; earlier-written data intact after re-init.
